// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: the machine word, the memory-stage FSM states
// and the decoded memory-operation bundle.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mem_state_t;

  // One-hot-ish view of the op held in the memory stage.
  typedef struct packed {
    logic read;
    logic write;
    logic ll;
    logic sc;
  } mem_op_t;

  localparam mem_op_t OP_NONE = '0;

  // A write wins if both read and write are raised, so the request lines
  // can never both be high. LL only makes sense on a read, SC on a write.
  function automatic mem_op_t decode_op(input logic mem_read,
                                        input logic mem_write,
                                        input logic ll,
                                        input logic sc);
    mem_op_t op;
    op.write = mem_write;
    op.read  = mem_read & ~mem_write;
    op.ll    = ll & mem_read & ~mem_write;
    op.sc    = sc & mem_write;
    return op;
  endfunction

endpackage

// File: rtl/link_reg.sv
// LL/SC reservation: remembers the address of the last completed LL and
// drops the reservation on a matching coherence invalidate or local store.
module link_reg
  import cpu_types_pkg::*;
(
  input  logic  CLK,
  input  logic  nRST,
  input  logic  set,
  input  word_t set_addr,
  input  logic  write_done,
  input  word_t write_addr,
  input  logic  ccinv,
  input  word_t ccsnoopaddr,
  input  word_t check_addr,
  output logic  match
);

  logic  valid_reg;
  word_t addr_reg;
  logic  snoop_hit_new;
  logic  snoop_hit_cur;
  logic  write_hit;

  // An invalidate to the address being linked this very cycle must win.
  assign snoop_hit_new = ccinv & (ccsnoopaddr == set_addr);
  assign snoop_hit_cur = ccinv & (ccsnoopaddr == addr_reg);
  assign write_hit     = write_done & (write_addr == addr_reg);

  // Reservation register: set by LL completion, cleared by invalidate/store.
  always_ff @(posedge CLK, negedge nRST) begin
    if (!nRST) begin
      valid_reg <= 1'b0;
      addr_reg  <= '0;
    end else if (set) begin
      addr_reg  <= set_addr;
      valid_reg <= ~snoop_hit_new;
    end else if (snoop_hit_cur | write_hit) begin
      valid_reg <= 1'b0;
    end
  end

  // SC succeeds only against a live reservation on the same word.
  always_comb begin
    match = valid_reg & (addr_reg == check_addr);
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-stage controller: accepts one load/store from EX/MEM, holds the
// dcache request until dhit, returns the result with a one-cycle mem_done
// pulse and stalls the upstream pipe while the access is outstanding.
module mem_access_ctrl
  import cpu_types_pkg::*;
(
  input  logic  CLK,
  input  logic  nRST,
  input  logic  ex_valid,
  input  logic  ex_MemRead,
  input  logic  ex_MemWrite,
  input  logic  ex_LL,
  input  logic  ex_SC,
  input  word_t ex_addr,
  input  word_t ex_wdata,
  input  logic  flush,
  input  logic  dhit,
  input  word_t dmemload,
  input  logic  ccinv,
  input  word_t ccsnoopaddr,
  output logic  dmemREN,
  output logic  dmemWEN,
  output word_t dmemaddr,
  output word_t dmemstore,
  output word_t dload,
  output logic  datomic,
  output logic  mem_done,
  output logic  stall
);

  mem_state_t state_reg;
  mem_state_t state_next;
  mem_op_t    op_reg;
  word_t      addr_reg;
  word_t      wdata_reg;
  word_t      dload_reg;
  logic       datomic_reg;

  logic accept;
  logic link_match;
  logic sc_fail;
  logic complete;

  // An op is taken only from IDLE; flush squashes it before acceptance.
  assign accept   = ex_valid & (ex_MemRead | ex_MemWrite) & ~flush;
  // A store-conditional without a matching reservation never reaches the cache.
  assign sc_fail  = ex_SC & ex_MemWrite & ~link_match;
  assign complete = (state_reg == BUSY) & dhit;

  link_reg u_link_reg (
    .CLK         (CLK),
    .nRST        (nRST),
    .set         (complete & op_reg.ll),
    .set_addr    (addr_reg),
    .write_done  (complete & op_reg.write),
    .write_addr  (addr_reg),
    .ccinv       (ccinv),
    .ccsnoopaddr (ccsnoopaddr),
    .check_addr  (ex_addr),
    .match       (link_match)
  );

  // FSM state register.
  always_ff @(posedge CLK, negedge nRST) begin
    if (!nRST) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM next-state: failed SC skips BUSY and completes straight away.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next = sc_fail ? DONE : BUSY;
        end
      end
      BUSY: begin
        if (dhit) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Latch the accepted op and capture load data / SC result on completion.
  always_ff @(posedge CLK, negedge nRST) begin
    if (!nRST) begin
      op_reg      <= OP_NONE;
      addr_reg    <= '0;
      wdata_reg   <= '0;
      dload_reg   <= '0;
      datomic_reg <= 1'b0;
    end else begin
      if ((state_reg == IDLE) && accept) begin
        op_reg    <= decode_op(ex_MemRead, ex_MemWrite, ex_LL, ex_SC);
        addr_reg  <= ex_addr;
        wdata_reg <= ex_wdata;
        if (sc_fail) begin
          datomic_reg <= 1'b0;
        end
      end
      if (complete) begin
        if (op_reg.read) begin
          dload_reg <= dmemload;
        end
        // Any op that reaches the cache as an SC has already won its reservation.
        datomic_reg <= op_reg.sc;
      end
    end
  end

  // FSM outputs: requests only in BUSY, stall while an op is pending.
  always_comb begin
    dmemREN   = 1'b0;
    dmemWEN   = 1'b0;
    mem_done  = 1'b0;
    stall     = 1'b0;
    dmemaddr  = addr_reg;
    dmemstore = wdata_reg;
    dload     = dload_reg;
    datomic   = datomic_reg;
    case (state_reg)
      IDLE: begin
        // Gated by nRST so that stall is low while reset is held.
        stall = accept & nRST;
      end
      BUSY: begin
        dmemREN = op_reg.read;
        dmemWEN = op_reg.write;
        stall   = 1'b1;
      end
      DONE: begin
        mem_done = 1'b1;
      end
      default: begin
        stall = 1'b0;
      end
    endcase
  end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have the following ports, one per line: name, direction, width, meaning.
- CLK  in  1  clock, rising edge
- nRST  in  1  reset, asynchronous, active-low
- ex_valid  in  1  EX/MEM stage holds a valid instruction
- ex_MemRead  in  1  LW or LL
- ex_MemWrite  in  1  SW or SC
- ex_LL  in  1  load-linked
- ex_SC  in  1  store-conditional
- ex_addr  in  32  word address
- ex_wdata  in  32  store data
- flush  in  1  squash the op not yet accepted
- dhit  in  1  dcache completion
- dmemload  in  32  dcache read data
- ccinv  in  1  coherence invalidate
- ccsnoopaddr  in  32  invalidated address
- dmemREN  out  1  dcache read request
- dmemWEN  out  1  dcache write request
- dmemaddr  out  32  request address
- dmemstore  out  32  request store data
- dload  out  32  registered load result to the MEM/WB latch
- datomic  out  1  SC result, 1 = success
- mem_done  out  1  one-cycle pulse; MEM/WB latch captures on it
- stall  out  1  freeze upstream stages

Function
REQ-002 SHALL use an FSM with states IDLE, BUSY and DONE.
REQ-003 IDLE: if ex_valid & (ex_MemRead|ex_MemWrite) & !flush, SHALL latch addr, wdata, op and go to BUSY next cycle. Otherwise SHALL remain in IDLE.
REQ-004 SC failure in IDLE (ex_SC & (!link_valid | link_addr != ex_addr)) SHALL go directly to DONE with datomic=0. No dmemWEN SHALL be issued.
REQ-005 BUSY SHALL drive dmemREN (read) or dmemWEN (write) with dmemaddr/dmemstore from latched values, held stable until dhit.
REQ-006 BUSY with dhit SHALL capture dmemload into dload (reads only), set datomic=1 for SC, and go to DONE.
REQ-007 DONE SHALL assert mem_done for exactly one cycle and return to IDLE.
REQ-008 stall SHALL be 1 in IDLE-with-accepted-op and in BUSY. stall SHALL be 0 in DONE and in idle IDLE.
REQ-009 Best-case latency: accept to mem_done = 2 cycles (dhit in first BUSY cycle). Failed SC = 1 cycle.
REQ-010 flush SHALL affect only IDLE acceptance. An op already in BUSY SHALL complete normally.
REQ-011 LL completing on dhit SHALL set link_valid=1 and link_addr=addr.
REQ-012 link_valid SHALL be cleared when either event occurs:
- ccinv & ccsnoopaddr==link_addr
- any completed local write (SW or successful SC) to link_addr
REQ-013 Clear SHALL win over set when ccinv to the same address coincides with LL dhit.
REQ-014 dload and datomic SHALL hold their value until the next capture. datomic SHALL be 0 for non-SC ops.
REQ-015 dmemREN and dmemWEN SHALL never be asserted together, and SHALL be 0 outside BUSY.

Reset
REQ-016 On nRST low, state=IDLE; dload, datomic, link_valid, link_addr and latched regs SHALL all be 0; all outputs SHALL be 0.
REQ-017 Reset mid-BUSY SHALL drop the request immediately. No mem_done SHALL follow.

Structure
REQ-018 word_t and the FSM state enum SHALL reside in cpu_types_pkg.
REQ-019 The LL/SC link register and its compare/invalidate logic SHALL be the sub-module link_reg. All else SHALL be flat.

Verification
REQ-020 Stimulus: LW addr 0x0040, dhit after 3 BUSY cycles with dmemload 0xDEADBEEF. Required response: dmemREN held 3 cycles, dload=0xDEADBEEF, one mem_done pulse, stall low in DONE.
REQ-021 Stimulus: SW addr 0x0080 data 0x12345678, dhit first cycle. Required response: dmemWEN=1 with that addr/data for exactly one cycle, mem_done 2 cycles after accept.
REQ-022 Stimulus: LL 0x0100, then SC 0x0100. Required response: SC issues dmemWEN, datomic=1, and link_valid clears afterward.
REQ-023 Stimulus: LL 0x0100, ccinv 0x0100, then SC 0x0100. Required response: no dmemWEN, datomic=0, mem_done 1 cycle after accept.
REQ-024 Stimulus: flush with LW presented in IDLE. Required response: no request and no stall. Separately, flush during BUSY: transaction completes and mem_done pulses.
REQ-025 Stimulus: nRST low during BUSY. Required response: dmemREN drops asynchronously, all outputs 0, state IDLE.
